// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage next-PC logic and its BTB.
package pc_pkg;

    // 2-bit saturating branch-direction counter
    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'b00;  // strongly not taken
    localparam ctr_t CTR_WNT = 2'b01;  // weakly not taken (reset value)
    localparam ctr_t CTR_WT  = 2'b10;  // weakly taken (fresh allocation)
    localparam ctr_t CTR_ST  = 2'b11;  // strongly taken

    // Widest address the BTB entry record can carry; narrower cores
    // zero-extend tag and target into these fields.
    localparam int MAX_W = 64;

    typedef struct packed {
        logic             valid;
        logic [MAX_W-1:0] tag;
        logic [MAX_W-1:0] target;
        ctr_t             ctr;
    } btb_entry_t;

    // Saturating increment on taken, saturating decrement on not taken.
    function automatic ctr_t sat_update(ctr_t ctr, logic taken);
        ctr_t res;
        if (taken) begin
            res = (ctr == CTR_ST) ? CTR_ST : ctr_t'(ctr + 2'b01);
        end else begin
            res = (ctr == CTR_SNT) ? CTR_SNT : ctr_t'(ctr - 2'b01);
        end
        return res;
    endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped branch target buffer: combinational lookup port,
// synchronous update port, reset clears valid bits and counters.
module btb_table
    import pc_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int BTB_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] lookup_pc_i,
    output logic             hit_o,
    output ctr_t             ctr_o,
    output logic [WIDTH-1:0] target_o,
    input  logic             upd_valid_i,
    input  logic [WIDTH-1:0] upd_pc_i,
    input  logic [WIDTH-1:0] upd_target_i,
    input  logic             upd_taken_i
);

    localparam int IDX_BITS = $clog2(BTB_DEPTH);
    localparam int TAG_W    = WIDTH - IDX_BITS - 2;

    btb_entry_t entries_q [BTB_DEPTH];

    logic [IDX_BITS-1:0] rd_idx;
    logic [IDX_BITS-1:0] wr_idx;
    logic [TAG_W-1:0]    rd_tag;
    logic [TAG_W-1:0]    wr_tag;
    btb_entry_t          rd_ent;
    btb_entry_t          wr_ent;
    logic                wr_hit;

    // Address split: bits [1:0] never participate in index or tag.
    assign rd_idx = lookup_pc_i[IDX_BITS+1:2];
    assign rd_tag = lookup_pc_i[WIDTH-1:IDX_BITS+2];
    assign wr_idx = upd_pc_i[IDX_BITS+1:2];
    assign wr_tag = upd_pc_i[WIDTH-1:IDX_BITS+2];

    assign rd_ent = entries_q[rd_idx];
    assign wr_ent = entries_q[wr_idx];

    // Lookup: reads the pre-update array contents, no write bypass.
    always_comb begin
        hit_o    = rd_ent.valid && (rd_ent.tag[TAG_W-1:0] == rd_tag);
        ctr_o    = rd_ent.ctr;
        target_o = rd_ent.target[WIDTH-1:0];
    end

    assign wr_hit = wr_ent.valid && (wr_ent.tag[TAG_W-1:0] == wr_tag);

    // Folds the alignment bits and the unused high bits of the wide entry record.
    logic unused_bits;
    assign unused_bits = ^{rd_ent, wr_ent, lookup_pc_i[1:0], upd_pc_i[1:0]};

    // Entry array: reset clears control fields, update trains or allocates.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                entries_q[i].valid <= 1'b0;
                entries_q[i].ctr   <= CTR_WNT;
            end
        end else if (upd_valid_i) begin
            if (wr_hit) begin
                entries_q[wr_idx].ctr <= sat_update(wr_ent.ctr, upd_taken_i);
                if (upd_taken_i) begin
                    entries_q[wr_idx].target <= MAX_W'(upd_target_i);
                end
            end else if (upd_taken_i) begin
                entries_q[wr_idx] <= '{valid:  1'b1,
                                       tag:    MAX_W'(wr_tag),
                                       target: MAX_W'(upd_target_i),
                                       ctr:    CTR_WT};
            end
        end
    end

endmodule

// File: rtl/next_pc_unit.sv
// Fetch-stage program counter with redirect, stall and BTB-driven
// next-address prediction.
module next_pc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter int               BTB_DEPTH    = 16,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             upd_valid,
    input  logic [WIDTH-1:0] upd_pc,
    input  logic [WIDTH-1:0] upd_target,
    input  logic             upd_taken,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PCPlus4,
    output logic             pred_taken,
    output logic [WIDTH-1:0] pred_target
);

    logic [WIDTH-1:0] PC_q;
    logic [WIDTH-1:0] PC_d;
    logic             btb_hit;
    ctr_t             btb_ctr;
    logic [WIDTH-1:0] btb_target;

    btb_table #(
        .WIDTH     (WIDTH),
        .BTB_DEPTH (BTB_DEPTH)
    ) u_btb (
        .clk          (clk),
        .rst          (rst),
        .lookup_pc_i  (PC_q),
        .hit_o        (btb_hit),
        .ctr_o        (btb_ctr),
        .target_o     (btb_target),
        .upd_valid_i  (upd_valid),
        .upd_pc_i     (upd_pc),
        .upd_target_i (upd_target),
        .upd_taken_i  (upd_taken)
    );

    assign PC          = PC_q;
    assign PCPlus4     = PC_q + WIDTH'(4);
    assign pred_taken  = btb_hit && btb_ctr[1];
    assign pred_target = pred_taken ? btb_target : '0;

    // Next-PC priority: redirect beats stall, stall beats prediction.
    always_comb begin
        PC_d = PCPlus4;
        if (redirect) begin
            PC_d = redirect_pc;
        end else if (stall) begin
            PC_d = PC_q;
        end else if (pred_taken) begin
            PC_d = pred_target;
        end
    end

    // PC register; reset overrides everything in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            PC_q <= RESET_VECTOR;
        end else begin
            PC_q <= PC_d;
        end
    end

endmodule
